// File: rtl/rv32i_decode_unit_if.sv
// Fetch-to-decode handshake and decoded-field bundle for rv32i_decode_unit.
// master: fetch side (drives Fetch_ready/instruction); slave: decoder.
interface rv32i_decode_unit_if #(
  parameter int XLEN = 32
);
  logic            Fetch_ready;
  logic [XLEN-1:0] instruction;
  logic            IDU_ready;
  logic [5:0]      Instruction_to_CU;
  logic [4:0]      Instruction_to_ALU;
  logic [XLEN-1:0] imm;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      shamt;
  logic [XLEN-1:0] pc_increment;
  logic [1:0]      pipeline_override;
  logic            invalid_instruction;

  modport master (
    output Fetch_ready, instruction,
    input  IDU_ready, Instruction_to_CU,
    input  Instruction_to_ALU, imm, rd,
    input  rs1, rs2, shamt, pc_increment,
    input  pipeline_override,
    input  invalid_instruction
  );

  modport slave (
    input  Fetch_ready, instruction,
    output IDU_ready, Instruction_to_CU,
    output Instruction_to_ALU, imm, rd,
    output rs1, rs2, shamt, pc_increment,
    output pipeline_override,
    output invalid_instruction
  );
endinterface

// File: rtl/rv32i_decode_unit.sv
// RV32I decoder: registers+decodes one instruction per Fetch_ready.
// Ports: soc_clk, reset (async, active-low), dif (slave: fetch in,
// decoded fields out). Macro RV32I_DECODE_HAZARD_EN enables
// pipeline_override (RAW vs previous rd); undefined ties it to 00.
module rv32i_decode_unit #(
  parameter int XLEN = 32
) (
  input logic                soc_clk,
  input logic                reset,
  rv32i_decode_unit_if.slave dif
);
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6f;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_LD    = 7'h03;
  localparam logic [6:0] OP_ST    = 7'h23;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_REG   = 7'h33;
  localparam logic [6:0] OP_FENCE = 7'h0f;
  localparam logic [6:0] OP_SYS   = 7'h73;

  localparam logic [4:0] A_ADD   = 5'd0;
  localparam logic [4:0] A_SUB   = 5'd1;
  localparam logic [4:0] A_SLL   = 5'd2;
  localparam logic [4:0] A_SLT   = 5'd3;
  localparam logic [4:0] A_SLTU  = 5'd4;
  localparam logic [4:0] A_XOR   = 5'd5;
  localparam logic [4:0] A_SRL   = 5'd6;
  localparam logic [4:0] A_SRA   = 5'd7;
  localparam logic [4:0] A_OR    = 5'd8;
  localparam logic [4:0] A_AND   = 5'd9;
  localparam logic [4:0] A_EQ    = 5'd10;
  localparam logic [4:0] A_NE    = 5'd11;
  localparam logic [4:0] A_LT    = 5'd12;
  localparam logic [4:0] A_GE    = 5'd13;
  localparam logic [4:0] A_LTU   = 5'd14;
  localparam logic [4:0] A_GEU   = 5'd15;
  localparam logic [4:0] A_PASSB = 5'd16;
  localparam logic [4:0] A_NOP   = 5'd31;

  localparam logic [5:0] CU_BAD = 6'd63;

  logic [XLEN-1:0] ins;
  logic [6:0]      op;
  logic [6:0]      f7;
  logic [2:0]      f3;
  logic [4:0]      f_rd;
  logic [4:0]      f_rs1;
  logic [4:0]      f_rs2;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] s_imm;
  logic [XLEN-1:0] b_imm;
  logic [XLEN-1:0] u_imm;
  logic [XLEN-1:0] j_imm;

  assign ins   = dif.instruction;
  assign op    = ins[6:0];
  assign f_rd  = ins[11:7];
  assign f3    = ins[14:12];
  assign f_rs1 = ins[19:15];
  assign f_rs2 = ins[24:20];
  assign f7    = ins[31:25];

  assign i_imm = {{20{ins[31]}}, ins[31:20]};
  assign s_imm = {{20{ins[31]}}, ins[31:25],
                  ins[11:7]};
  assign b_imm = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign u_imm = {ins[31:12], 12'h000};
  assign j_imm = {{11{ins[31]}}, ins[31],
                  ins[19:12], ins[20],
                  ins[30:21], 1'b0};

  logic            ok;
  logic [5:0]      cu_n;
  logic [4:0]      alu_n;
  logic [XLEN-1:0] imm_n;
  logic [4:0]      rd_n;
  logic [4:0]      rs1_n;
  logic [4:0]      rs2_n;
  logic [4:0]      sh_n;
  logic [XLEN-1:0] pci_n;
  logic [1:0]      ovr_n;

  // Fields stay at their invalid-encoding values unless a
  // branch below recognises the encoding and sets ok.
  always_comb begin
    ok    = 1'b0;
    cu_n  = CU_BAD;
    alu_n = A_NOP;
    imm_n = '0;
    rd_n  = '0;
    rs1_n = '0;
    rs2_n = '0;
    sh_n  = '0;
    pci_n = 32'd4;
    unique case (1'b1)
      op == OP_LUI: begin
        ok    = 1'b1;
        cu_n  = 6'd0;
        alu_n = A_PASSB;
        imm_n = u_imm;
        rd_n  = f_rd;
      end
      op == OP_AUIPC: begin
        ok    = 1'b1;
        cu_n  = 6'd1;
        alu_n = A_ADD;
        imm_n = u_imm;
        rd_n  = f_rd;
      end
      op == OP_JAL: begin
        ok    = 1'b1;
        cu_n  = 6'd2;
        alu_n = A_ADD;
        imm_n = j_imm;
        pci_n = j_imm;
        rd_n  = f_rd;
      end
      op == OP_JALR: begin
        if (f3 == 3'b000) begin
          ok    = 1'b1;
          cu_n  = 6'd3;
          alu_n = A_ADD;
          imm_n = i_imm;
          pci_n = '0;
          rd_n  = f_rd;
          rs1_n = f_rs1;
        end
      end
      op == OP_BR: begin
        ok = 1'b1;
        case (f3)
          3'b000: begin cu_n = 6'd4; alu_n = A_EQ;  end
          3'b001: begin cu_n = 6'd5; alu_n = A_NE;  end
          3'b100: begin cu_n = 6'd6; alu_n = A_LT;  end
          3'b101: begin cu_n = 6'd7; alu_n = A_GE;  end
          3'b110: begin cu_n = 6'd8; alu_n = A_LTU; end
          3'b111: begin cu_n = 6'd9; alu_n = A_GEU; end
          default: ok = 1'b0;
        endcase
        if (ok) begin
          imm_n = b_imm;
          pci_n = b_imm;
          rs1_n = f_rs1;
          rs2_n = f_rs2;
        end
      end
      op == OP_LD: begin
        ok = 1'b1;
        case (f3)
          3'b000:  cu_n = 6'd10;
          3'b001:  cu_n = 6'd11;
          3'b010:  cu_n = 6'd12;
          3'b100:  cu_n = 6'd13;
          3'b101:  cu_n = 6'd14;
          default: ok = 1'b0;
        endcase
        if (ok) begin
          alu_n = A_ADD;
          imm_n = i_imm;
          rd_n  = f_rd;
          rs1_n = f_rs1;
        end
      end
      op == OP_ST: begin
        ok = 1'b1;
        case (f3)
          3'b000:  cu_n = 6'd15;
          3'b001:  cu_n = 6'd16;
          3'b010:  cu_n = 6'd17;
          default: ok = 1'b0;
        endcase
        if (ok) begin
          alu_n = A_ADD;
          imm_n = s_imm;
          rs1_n = f_rs1;
          rs2_n = f_rs2;
        end
      end
      op == OP_IMM: begin
        ok = 1'b1;
        case (f3)
          3'b000: begin cu_n = 6'd18; alu_n = A_ADD;  end
          3'b010: begin cu_n = 6'd19; alu_n = A_SLT;  end
          3'b011: begin cu_n = 6'd20; alu_n = A_SLTU; end
          3'b100: begin cu_n = 6'd21; alu_n = A_XOR;  end
          3'b110: begin cu_n = 6'd22; alu_n = A_OR;   end
          3'b111: begin cu_n = 6'd23; alu_n = A_AND;  end
          3'b001: begin
            if (f7 == 7'h00) begin
              cu_n  = 6'd24;
              alu_n = A_SLL;
            end else begin
              ok = 1'b0;
            end
          end
          default: begin
            if (f7 == 7'h00) begin
              cu_n  = 6'd25;
              alu_n = A_SRL;
            end else if (f7 == 7'h20) begin
              cu_n  = 6'd26;
              alu_n = A_SRA;
            end else begin
              ok = 1'b0;
            end
          end
        endcase
        if (ok) begin
          imm_n = i_imm;
          rd_n  = f_rd;
          rs1_n = f_rs1;
          if (f3[1:0] == 2'b01)
            sh_n = f_rs2;
        end
      end
      op == OP_REG: begin
        ok = 1'b1;
        case ({f7, f3})
          {7'h00, 3'b000}: begin cu_n = 6'd27; alu_n = A_ADD;  end
          {7'h20, 3'b000}: begin cu_n = 6'd28; alu_n = A_SUB;  end
          {7'h00, 3'b001}: begin cu_n = 6'd29; alu_n = A_SLL;  end
          {7'h00, 3'b010}: begin cu_n = 6'd30; alu_n = A_SLT;  end
          {7'h00, 3'b011}: begin cu_n = 6'd31; alu_n = A_SLTU; end
          {7'h00, 3'b100}: begin cu_n = 6'd32; alu_n = A_XOR;  end
          {7'h00, 3'b101}: begin cu_n = 6'd33; alu_n = A_SRL;  end
          {7'h20, 3'b101}: begin cu_n = 6'd34; alu_n = A_SRA;  end
          {7'h00, 3'b110}: begin cu_n = 6'd35; alu_n = A_OR;   end
          {7'h00, 3'b111}: begin cu_n = 6'd36; alu_n = A_AND;  end
          default: ok = 1'b0;
        endcase
        if (ok) begin
          rd_n  = f_rd;
          rs1_n = f_rs1;
          rs2_n = f_rs2;
        end
      end
      op == OP_FENCE: begin
        if (f3 == 3'b000) begin
          ok   = 1'b1;
          cu_n = 6'd37;
        end
      end
      op == OP_SYS: begin
        if (ins == 32'h0000_0073) begin
          ok   = 1'b1;
          cu_n = 6'd38;
        end else if (ins == 32'h0010_0073) begin
          ok   = 1'b1;
          cu_n = 6'd39;
        end
      end
      default: ;
    endcase
  end

`ifdef RV32I_DECODE_HAZARD_EN
  logic [4:0] prev_rd;
  logic       prev_writes;
  logic       wr_n;

  assign wr_n = ok && (op == OP_LUI || op == OP_AUIPC ||
                op == OP_JAL || op == OP_JALR ||
                op == OP_LD || op == OP_IMM ||
                op == OP_REG);

  // rs1_n/rs2_n are zero when the format has no such
  // source, so the prev_rd!=0 test also covers "used".
  assign ovr_n[0] = prev_writes && (prev_rd != 5'd0) &&
                    (rs1_n == prev_rd);
  assign ovr_n[1] = prev_writes && (prev_rd != 5'd0) &&
                    (rs2_n == prev_rd);

  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      prev_rd     <= '0;
      prev_writes <= 1'b0;
    end else if (dif.Fetch_ready) begin
      prev_rd     <= rd_n;
      prev_writes <= wr_n;
    end
  end
`else
  assign ovr_n = 2'b00;
`endif

  logic            rdy_q;
  logic [5:0]      cu_q;
  logic [4:0]      alu_q;
  logic [XLEN-1:0] imm_q;
  logic [4:0]      rd_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic [4:0]      sh_q;
  logic [XLEN-1:0] pci_q;
  logic [1:0]      ovr_q;
  logic            inv_q;

  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      rdy_q <= 1'b0;
      cu_q  <= '0;
      alu_q <= '0;
      imm_q <= '0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      sh_q  <= '0;
      pci_q <= '0;
      ovr_q <= '0;
      inv_q <= 1'b0;
    end else begin
      rdy_q <= dif.Fetch_ready;
      if (dif.Fetch_ready) begin
        cu_q  <= cu_n;
        alu_q <= alu_n;
        imm_q <= imm_n;
        rd_q  <= rd_n;
        rs1_q <= rs1_n;
        rs2_q <= rs2_n;
        sh_q  <= sh_n;
        pci_q <= pci_n;
        ovr_q <= ovr_n;
        inv_q <= !ok;
      end
    end
  end

  assign dif.IDU_ready           = rdy_q;
  assign dif.Instruction_to_CU   = cu_q;
  assign dif.Instruction_to_ALU  = alu_q;
  assign dif.imm                 = imm_q;
  assign dif.rd                  = rd_q;
  assign dif.rs1                 = rs1_q;
  assign dif.rs2                 = rs2_q;
  assign dif.shamt               = sh_q;
  assign dif.pc_increment        = pci_q;
  assign dif.pipeline_override   = ovr_q;
  assign dif.invalid_instruction = inv_q;
endmodule

// File: tb/tb_rv32i_decode_unit.sv
// Bench for rv32i_decode_unit: directed + random decodes checked
// against a pattern-table reference model of RV32I.
module tb_rv32i_decode_unit;
  logic soc_clk = 1'b0;
  logic reset   = 1'b0;
  always #5 soc_clk = ~soc_clk;

  rv32i_decode_unit_if dif ();

  rv32i_decode_unit dut (
    .soc_clk(soc_clk),
    .reset  (reset),
    .dif    (dif)
  );

  localparam int FR = 0, FI = 1, FS = 2, FB = 3;
  localparam int FU = 4, FJ = 5, FSH = 6, FN = 7, FJR = 8;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int          cu;
    int          alu;
    int          fmt;
  } pat_t;

  typedef struct {
    logic        rdy;
    logic [5:0]  cu;
    logic [4:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  sh;
    logic [31:0] pci;
    logic [1:0]  ovr;
    logic        inv;
    logic        wr;
  } exp_t;

  pat_t        pats[$];
  exp_t        cur;
  logic [4:0]  prev_rd;
  logic        prev_w;
  int          nvec = 0;
  int          nerr = 0;
  logic [6:0]  ops[11] = '{7'h37, 7'h17, 7'h6f, 7'h67,
                           7'h63, 7'h03, 7'h23, 7'h13,
                           7'h33, 7'h0f, 7'h73};

  function automatic void add(logic [31:0] m, logic [31:0] mt,
                              int cu, int alu, int fmt);
    pat_t p;
    p.mask = m; p.match = mt;
    p.cu = cu; p.alu = alu; p.fmt = fmt;
    pats.push_back(p);
  endfunction

  function automatic void build();
    int bf3[6] = '{0, 1, 4, 5, 6, 7};
    int if3[6] = '{0, 2, 3, 4, 6, 7};
    int ial[6] = '{0, 3, 4, 5, 8, 9};
    int lf3[5] = '{0, 1, 2, 4, 5};
    int of7[10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
    int of3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    add(32'h7f, 32'h37, 0, 16, FU);
    add(32'h7f, 32'h17, 1, 0, FU);
    add(32'h7f, 32'h6f, 2, 0, FJ);
    add(32'h707f, 32'h67, 3, 0, FJR);
    for (int i = 0; i < 6; i++)
      add(32'h707f, 32'h63 | (32'(bf3[i]) << 12),
          4 + i, 10 + i, FB);
    for (int i = 0; i < 5; i++)
      add(32'h707f, 32'h03 | (32'(lf3[i]) << 12),
          10 + i, 0, FI);
    for (int i = 0; i < 3; i++)
      add(32'h707f, 32'h23 | (32'(i) << 12), 15 + i, 0, FS);
    for (int i = 0; i < 6; i++)
      add(32'h707f, 32'h13 | (32'(if3[i]) << 12),
          18 + i, ial[i], FI);
    add(32'hfe00707f, 32'h00001013, 24, 2, FSH);
    add(32'hfe00707f, 32'h00005013, 25, 6, FSH);
    add(32'hfe00707f, 32'h40005013, 26, 7, FSH);
    for (int i = 0; i < 10; i++)
      add(32'hfe00707f, 32'h33 | (32'(of3[i]) << 12) |
          (32'(of7[i]) << 25), 27 + i, i, FR);
    add(32'h707f, 32'h0f, 37, 31, FN);
    add(32'hffffffff, 32'h00000073, 38, 31, FN);
    add(32'hffffffff, 32'h00100073, 39, 31, FN);
  endfunction

  function automatic exp_t ref_decode(logic [31:0] w);
    exp_t e;
    int   hit;
    int   f;
    hit = -1;
    for (int i = 0; i < pats.size(); i++)
      if ((w & pats[i].mask) == pats[i].match) hit = i;
    e.rdy = 1'b1; e.cu = 6'd63; e.alu = 5'd31; e.imm = '0;
    e.rd = '0; e.rs1 = '0; e.rs2 = '0; e.sh = '0;
    e.pci = 32'd4; e.ovr = '0; e.inv = 1'b1; e.wr = 1'b0;
    if (hit >= 0) begin
      f = pats[hit].fmt;
      e.inv = 1'b0;
      e.cu  = 6'(pats[hit].cu);
      e.alu = 5'(pats[hit].alu);
      case (f)
        FI, FJR, FSH: e.imm = {{20{w[31]}}, w[31:20]};
        FS: e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
        FB: e.imm = {{19{w[31]}}, w[31], w[7], w[30:25],
                     w[11:8], 1'b0};
        FU: e.imm = {w[31:12], 12'h000};
        FJ: e.imm = {{11{w[31]}}, w[31], w[19:12], w[20],
                     w[30:21], 1'b0};
        default: e.imm = '0;
      endcase
      if (f inside {FR, FI, FU, FJ, FSH, FJR}) e.rd = w[11:7];
      if (f inside {FR, FI, FS, FB, FSH, FJR}) e.rs1 = w[19:15];
      if (f inside {FR, FS, FB}) e.rs2 = w[24:20];
      if (f == FSH) e.sh = w[24:20];
      if (f == FB || f == FJ) e.pci = e.imm;
      if (f == FJR) e.pci = '0;
      e.wr = (pats[hit].cu <= 3) ||
             (pats[hit].cu >= 10 && pats[hit].cu <= 14) ||
             (pats[hit].cu >= 18 && pats[hit].cu <= 36);
    end
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string t);
    chk({t, ".rdy"}, 32'(dif.IDU_ready), 32'(cur.rdy));
    chk({t, ".cu"}, 32'(dif.Instruction_to_CU), 32'(cur.cu));
    chk({t, ".alu"}, 32'(dif.Instruction_to_ALU), 32'(cur.alu));
    chk({t, ".imm"}, dif.imm, cur.imm);
    chk({t, ".rd"}, 32'(dif.rd), 32'(cur.rd));
    chk({t, ".rs1"}, 32'(dif.rs1), 32'(cur.rs1));
    chk({t, ".rs2"}, 32'(dif.rs2), 32'(cur.rs2));
    chk({t, ".shamt"}, 32'(dif.shamt), 32'(cur.sh));
    chk({t, ".pci"}, dif.pc_increment, cur.pci);
    chk({t, ".ovr"}, 32'(dif.pipeline_override), 32'(cur.ovr));
    chk({t, ".inv"}, 32'(dif.invalid_instruction), 32'(cur.inv));
  endtask

  task automatic model_reset();
    cur = '{default: '0};
    prev_rd = '0;
    prev_w = 1'b0;
  endtask

  task automatic apply(bit fr, logic [31:0] w, string t);
    exp_t d;
    @(negedge soc_clk);
    dif.Fetch_ready = fr;
    dif.instruction = w;
    @(posedge soc_clk);
    #1;
    cur.rdy = fr;
    if (fr) begin
      d = ref_decode(w);
`ifdef RV32I_DECODE_HAZARD_EN
      d.ovr[0] = prev_w && prev_rd != 0 && d.rs1 == prev_rd;
      d.ovr[1] = prev_w && prev_rd != 0 && d.rs2 == prev_rd;
`else
      d.ovr = 2'b00;
`endif
      prev_rd = d.rd;
      prev_w  = d.wr;
      cur = d;
    end
    check_all(t);
  endtask

  initial begin
    logic [31:0] w;
    logic [4:0]  last_rd;
    int          k;
    int          p;
    bit          fr;
    build();
    model_reset();
    dif.Fetch_ready = 1'b0;
    dif.instruction = '0;
    repeat (2) @(posedge soc_clk);
    #1;
    check_all("reset");
    @(negedge soc_clk);
    reset = 1'b1;

    apply(1, 32'h00500093, "addi");
    chk("addi.cu_k", 32'(dif.Instruction_to_CU), 32'd18);
    chk("addi.imm_k", dif.imm, 32'd5);
    apply(1, 32'h00108133, "add");
`ifdef RV32I_DECODE_HAZARD_EN
    chk("add.ovr_k", 32'(dif.pipeline_override), 32'd3);
`else
    chk("add.ovr_k", 32'(dif.pipeline_override), 32'd0);
`endif
    apply(0, 32'h0, "hold");
    apply(1, 32'hFE000CE3, "beq");
    chk("beq.pci_k", dif.pc_increment, 32'hFFFFFFF8);
    apply(1, 32'h4040D193, "srai");
    chk("srai.sh_k", 32'(dif.shamt), 32'd4);
    apply(1, 32'hFFFFFFFF, "bad");
    chk("bad.cu_k", 32'(dif.Instruction_to_CU), 32'd63);
    apply(0, 32'h00500093, "badhold");
    apply(1, 32'h00500093, "clear");
    chk("clear.inv_k", 32'(dif.invalid_instruction), 32'd0);

    last_rd = 5'd1;
    for (int n = 0; n < 400; n++) begin
      k = int'($urandom_range(0, 9));
      if (k < 7) begin
        p = int'($urandom_range(0, pats.size() - 1));
        w = pats[p].match | ($urandom & ~pats[p].mask);
        if (pats[p].mask[19:15] == 0 && $urandom_range(0, 1) == 1)
          w[19:15] = last_rd;
        if (pats[p].mask[24:20] == 0 && $urandom_range(0, 1) == 1)
          w[24:20] = last_rd;
      end else if (k < 9) begin
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 10)];
      end else begin
        w = $urandom;
      end
      fr = ($urandom_range(0, 3) != 0);
      apply(fr, w, "rand");
      if (fr) last_rd = w[11:7];
    end

    apply(1, 32'h00500093, "pre_rst");
    @(negedge soc_clk);
    dif.Fetch_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("areset");
    @(negedge soc_clk);
    reset = 1'b1;
    apply(1, 32'h00108133, "post_rst");
    chk("post_rst.ovr_k", 32'(dif.pipeline_override), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule

// File: doc/rv32i_decode_unit.md
Name: rv32i_decode_unit

Overview:
- RV32I instruction decoder between the fetch path and the control unit's 4-phase result sequencer.
- On a fetch-ready strobe it registers one 32-bit instruction and fully decodes it: control opcode, ALU opcode, sign-extended immediate, register fields, shift amount and PC increment.
- Flags invalid encodings and read-after-write dependencies on the previously decoded instruction so the CU can forward rs1/rs2.

Parameters:
- XLEN, 32, datapath/instruction width; only 32 is supported.

Ports:
- soc_clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- Fetch_ready  input  1  instruction valid strobe, sampled on soc_clk
- instruction  input  32  instruction word
- IDU_ready  output  1  one-cycle pulse: decoded outputs valid
- Instruction_to_CU  output  6  control opcode (table below)
- Instruction_to_ALU  output  5  ALU operation code
- imm  output  32  sign-extended immediate
- rd  output  5  destination register
- rs1  output  5  source register 1
- rs2  output  5  source register 2
- shamt  output  5  shift amount
- pc_increment  output  32  PC delta
- pipeline_override  output  2  forwarding request
- invalid_instruction  output  1  illegal encoding flag

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; previous-rd tracking cleared (prev_rd=0, prev_writes=0).
- Latency:
  - Fetch_ready=1 at edge N latches the decode; all outputs update at edge N and IDU_ready=1 for exactly that cycle.
  - Outputs hold their values until the next Fetch_ready.
  - Fetch_ready held high decodes on every edge.
- Instruction_to_CU codes:
  - 0 LUI, 1 AUIPC, 2 JAL, 3 JALR
  - 4-9 BEQ, BNE, BLT, BGE, BLTU, BGEU
  - 10-14 LB, LH, LW, LBU, LHU
  - 15-17 SB, SH, SW
  - 18-26 ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI
  - 27-36 ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
  - 37 FENCE, 38 ECALL, 39 EBREAK
  - 63 invalid
- Instruction_to_ALU codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - 10 EQ, 11 NE, 12 LT, 13 GE, 14 LTU, 15 GEU
  - 16 PASSB, 31 NOP
- ALU mapping:
  - AUIPC, JAL, JALR, loads, stores and ADDI map to ADD.
  - Branches map to their compare op; LUI maps to PASSB.
  - FENCE, ECALL, EBREAK and invalid map to NOP.
- imm: standard I/S/B/U/J format, sign-extended from bit 31; R-type, FENCE, ECALL and EBREAK give 0.
- shamt: instruction[24:20] for SLLI/SRLI/SRAI, else 0.
- Register fields: rd/rs1/rs2 report raw fields only where the format uses them, else 0.
- pc_increment:
  - Branch: B-imm.
  - JAL: J-imm.
  - JALR: 0 (CU computes the target).
  - All others: 4.
- Invalid encodings:
  - Unknown opcode, bad funct3, or bad funct7 (only 0x00, or 0x20 for SUB/SRA/SRAI).
  - SYSTEM other than 0x00000073 / 0x00100073.
  - Result: invalid_instruction=1, CU=63, ALU=NOP, other fields 0, pc_increment=4. The flag holds until the next decode.
- Hazard tracking:
  - prev_rd/prev_writes are updated at each decode.
  - prev_writes=1 for LUI, AUIPC, JAL, JALR, loads, OP-IMM and OP.
  - Invalid instructions clear prev_writes.
- pipeline_override:
  - bit0 = prev_writes && prev_rd!=0 && rs1 used && rs1==prev_rd.
  - bit1 = the same condition for rs2.
  - Encoding: 00 none, 01 rs1, 10 rs2, 11 both.

Optional Feature:
- RV32I_DECODE_HAZARD_EN defined: pipeline_override computed as above.
- Undefined: pipeline_override tied to 00 and the prev_rd tracking logic is removed.

Test Plan:
- Reset low mid-operation -> all outputs 0 immediately; after release, ADD x2,x1,x1 reports override 00 (prev_rd cleared).
- 0x00500093 (ADDI x1,x0,5) -> IDU_ready pulse, CU=18, ALU=0, imm=5, rd=1, rs1=0, pc_increment=4, override=00.
- Then 0x00108133 (ADD x2,x1,x1) -> CU=27, ALU=0, rd=2, rs1=rs2=1, imm=0, override=11 (macro on) / 00 (macro off).
- 0xFE000CE3 (BEQ x0,x0,-8) -> CU=4, ALU=10, imm=pc_increment=0xFFFFFFF8, override=00.
- 0x4040D193 (SRAI x3,x1,4) -> CU=26, ALU=7, shamt=4, rd=3, rs1=1.
- 0xFFFFFFFF -> invalid_instruction=1, CU=63, ALU=31; next valid decode clears the flag.
